// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM/winner encodings, BCD digit types, default match timing.
// Also provides the two-digit BCD increment used by the score counters and the win check.
package pong_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned DEF_WIN_SCORE   = 9;
  localparam int unsigned DEF_SERVE_DELAY = 50000000;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef struct packed {
    digit_t tens;
    digit_t ones;
  } score_t;

  // Tens is never incremented past 9 because scores stop at WIN_SCORE <= 99.
  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    if (s.ones == digit_t'(9)) begin
      r.tens = s.tens + digit_t'(1);
      r.ones = '0;
    end else begin
      r.tens = s.tens;
      r.ones = s.ones + digit_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Match-controller signal bundle: ball point pulses and start request in, BCD scores and
// match status out. master drives the requests; slave is the score keeper.
interface score_keeper_if;
  import pong_pkg::*;

  logic       start;
  logic       point_1;
  logic       point_2;
  digit_t     score_1_tens;
  digit_t     score_1_ones;
  digit_t     score_2_tens;
  digit_t     score_2_ones;
  logic       ball_hold;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output start, point_1, point_2,
    input  score_1_tens, score_1_ones, score_2_tens, score_2_ones,
    input  ball_hold, game_over, winner
  );

  modport slave (
    input  start, point_1, point_2,
    output score_1_tens, score_1_ones, score_2_tens, score_2_ones,
    output ball_hold, game_over, winner
  );

endinterface

// File: rtl/bcd_counter_2d.sv
// One player's two-digit BCD score; synchronous clear takes priority over increment.
module bcd_counter_2d
  import pong_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clr,
  input  logic   inc,
  output digit_t tens,
  output digit_t ones
);

  score_t cur;
  score_t nxt;

  assign nxt  = bcd_inc(cur);
  assign tens = cur.tens;
  assign ones = cur.ones;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= '0;
    end else if (clr) begin
      cur <= '0;
    end else if (inc) begin
      cur <= nxt;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Match controller: edge-detects ball point pulses and start, keeps BCD scores,
// sequences IDLE/SERVE/PLAY/OVER and holds the ball between rallies.
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
  parameter int unsigned SERVE_DELAY = DEF_SERVE_DELAY,
  parameter int unsigned CNT_W       = 26
)(
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  localparam digit_t     WIN_TENS = digit_t'(WIN_SCORE / 10);
  localparam digit_t     WIN_ONES = digit_t'(WIN_SCORE % 10);
  localparam score_t     WIN_VAL  = '{tens: WIN_TENS, ones: WIN_ONES};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       winner_r;
  logic             start_q, p1_q, p2_q;
  logic             start_ev, p1_ev, p2_ev;
  logic             clr, inc_1, inc_2;
  digit_t           s1_tens, s1_ones, s2_tens, s2_ones;
  score_t           s1_next, s2_next;

  always_comb begin
    start_ev = bus.start   & ~start_q;
    p1_ev    = bus.point_1 & ~p1_q;
    p2_ev    = bus.point_2 & ~p2_q;
    clr      = start_ev & ((state == IDLE) | (state == OVER));
    inc_1    = (state == PLAY) & p1_ev;
    // Simultaneous points: player 1 wins the tie, player 2's edge is dropped.
    inc_2    = (state == PLAY) & p2_ev & ~p1_ev;
  end

  assign s1_next = bcd_inc({s1_tens, s1_ones});
  assign s2_next = bcd_inc({s2_tens, s2_ones});

  bcd_counter_2d u_score_1 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc_1),
    .tens  (s1_tens),
    .ones  (s1_ones)
  );

  bcd_counter_2d u_score_2 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc_2),
    .tens  (s2_tens),
    .ones  (s2_ones)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      winner_r <= WIN_NONE;
      start_q  <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
    end else begin
      start_q <= bus.start;
      p1_q    <= bus.point_1;
      p2_q    <= bus.point_2;
      case (state)
        IDLE: begin
          if (start_ev) begin
            cnt   <= '0;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= PLAY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          if (p1_ev) begin
            if (s1_next == WIN_VAL) begin
              state    <= OVER;
              winner_r <= WIN_P1;
            end else begin
              state <= SERVE;
            end
          end else if (p2_ev) begin
            if (s2_next == WIN_VAL) begin
              state    <= OVER;
              winner_r <= WIN_P2;
            end else begin
              state <= SERVE;
            end
          end
        end
        default: begin
          if (start_ev) begin
            winner_r <= WIN_NONE;
            cnt      <= '0;
            state    <= SERVE;
          end
        end
      endcase
    end
  end

  assign bus.score_1_tens = s1_tens;
  assign bus.score_1_ones = s1_ones;
  assign bus.score_2_tens = s2_tens;
  assign bus.score_2_ones = s2_ones;
  assign bus.ball_hold    = (state != PLAY);
  assign bus.game_over    = (state == OVER);
  assign bus.winner       = winner_r;

endmodule
